// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone register slave: bus widths, FSM encoding
// and register map addresses.
package wb_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StAck  = 2'b10
  } wb_state_e;

  localparam logic [ADDR_W-1:0] ADDR_ID       = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_WCNT     = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_RW_FIRST = 4'h2;

  localparam int unsigned NUM_RW = 16 - 2;

endpackage

// File: rtl/wb_regfile.sv
// Register storage for the Wishbone slave: 14 read/write registers at 0x2..0xF
// plus the committed-write counter read at 0x1.
module wb_regfile
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] rw_q [NUM_RW];
  logic [DATA_W-1:0] wcnt_q;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic              wr_hit;

  assign wr_idx = wr_addr_i - ADDR_RW_FIRST;
  assign rd_idx = rd_addr_i - ADDR_RW_FIRST;
  // Writes to ID and WCNT are discarded and not counted.
  assign wr_hit = wr_en_i && (wr_addr_i >= ADDR_RW_FIRST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RW; i++) begin
        rw_q[i] <= '0;
      end
      wcnt_q <= '0;
    end else if (wr_hit) begin
      rw_q[wr_idx] <= wr_data_i;
      wcnt_q       <= wcnt_q + 8'd1;
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (rd_addr_i == ADDR_WCNT) begin
      rd_data_o = wcnt_q;
    end else if (rd_addr_i >= ADDR_RW_FIRST) begin
      rd_data_o = rw_q[rd_idx];
    end
  end

endmodule

// File: rtl/wishbone_reg_slave.sv
// Wishbone-classic register slave: latches a request, waits WAIT_STATES cycles
// (aborting if the strobe drops), then commits and acks for exactly one cycle.
module wishbone_reg_slave
  import wb_pkg::*;
#(
  parameter int unsigned       WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] ID_VALUE    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              we_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              ack_o
);

  localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_state_e         state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] dat_o_q, dat_o_d;
  logic              req;
  logic              enter_ack;
  logic              commit;
  logic [DATA_W-1:0] rf_rdata;
  logic [DATA_W-1:0] rd_mux;

  assign req = cyc_i & stb_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      adr_q      <= '0;
      wdat_q     <= '0;
      we_q       <= 1'b0;
      dat_o_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      we_q       <= we_d;
      dat_o_q    <= dat_o_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    we_d       = we_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          adr_d      = adr_i;
          wdat_d     = dat_i;
          we_d       = we_i;
          wait_cnt_d = WaitLoad;
          state_d    = (WAIT_STATES > 0) ? StWait : StAck;
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
        end else if (wait_cnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The *_d latch values are used so a zero-wait transfer commits from the
  // request accepted on this same edge.
  always_comb begin
    enter_ack = (state_d == StAck);
    commit    = enter_ack && we_d;
    rd_mux    = (adr_d == ADDR_ID) ? ID_VALUE : rf_rdata;
    dat_o_d   = (enter_ack && !we_d) ? rd_mux : '0;
    ack_o     = (state_q == StAck);
    dat_o     = dat_o_q;
  end

  wb_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (commit),
    .wr_addr_i (adr_d),
    .wr_data_i (wdat_d),
    .rd_addr_i (adr_d),
    .rd_data_o (rf_rdata)
  );

endmodule
